// File: rtl/mpr_bus_pkg.sv
// Shared types and constants for the MPR bus master: FSM states, widths and
// the default I/O page boundary.
package mpr_bus_pkg;

    localparam int MPR_COUNT = 8;
    localparam int SEL_W     = $clog2(MPR_COUNT);
    localparam int PAGE_BITS = 13;
    localparam int PHYS_W    = 21;
    localparam int LOG_W     = 16;

    localparam logic [PHYS_W-1:0] IO_PAGE_BASE_DEFAULT = 21'h1F0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DATA
    } bus_state_t;

    // Physical address is a plain concatenation: page register above the offset.
    function automatic logic [PHYS_W-1:0] make_phys(input logic [7:0]           page,
                                                    input logic [PAGE_BITS-1:0] offset);
        return {page, offset};
    endfunction

endpackage

// File: rtl/mpr_file.sv
// Eight 8-bit MPR page registers: synchronous write, combinational read-back
// port and a second combinational port used for address translation.
module mpr_file
    import mpr_bus_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [SEL_W-1:0] sel,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    input  logic [SEL_W-1:0] page_idx,
    output logic [7:0]       page
);

    logic [7:0] regs [MPR_COUNT];

    // NOTE: this small array is architecturally visible state with a defined
    // reset value, so it is reset like any flop; non-blocking keeps the write
    // invisible to same-cycle translation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MPR_COUNT; i++) regs[i] <= RESET_VALUE;
        end else if (we) begin
            regs[sel] <= wdata;
        end
    end

    assign rdata = regs[sel];
    assign page  = regs[page_idx];

endmodule

// File: rtl/mpr_bus_master.sv
// CPU-side bus initiator: MPR address translation, single-cycle memory strobes
// and I/O-page filtering. Define MPR_BUS_WAIT_EN to add the slow_mode wait state.
module mpr_bus_master
    import mpr_bus_pkg::*;
#(
    parameter logic [PHYS_W-1:0] IO_PAGE_BASE  = IO_PAGE_BASE_DEFAULT,
    parameter logic [7:0]        IO_READ_VALUE = 8'hFF,
    parameter logic [7:0]        MPR_RESET     = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MPR_BUS_WAIT_EN
    input  logic              slow_mode,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [LOG_W-1:0]  req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    input  logic              mpr_we,
    input  logic [SEL_W-1:0]  mpr_sel,
    input  logic [7:0]        mpr_wdata,
    output logic [7:0]        mpr_rdata,
    output logic [PHYS_W-1:0] mem_addr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              mem_re,
    output logic              mem_we,
    output logic              io_access
);

    bus_state_t state, state_nxt;
    logic       op_we;
    logic [7:0] page;
    logic       accept;
    logic       is_io;
    logic [7:0] rd_src;

    mpr_file #(.RESET_VALUE(MPR_RESET)) u_mpr_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (mpr_we),
        .sel      (mpr_sel),
        .wdata    (mpr_wdata),
        .rdata    (mpr_rdata),
        .page_idx (req_addr[LOG_W-1:PAGE_BITS]),
        .page     (page)
    );

    assign accept = (state == ST_IDLE) && req_valid;
    assign is_io  = (mem_addr >= IO_PAGE_BASE);

`ifdef MPR_BUS_WAIT_EN
    logic       slow;
    logic [7:0] rd_hold;

    // Memory data is only guaranteed for one edge after the strobe, so a
    // waited access keeps its own copy for the delayed response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow    <= 1'b0;
            rd_hold <= 8'h00;
        end else begin
            if (accept)             slow    <= slow_mode;
            if (state == ST_WAIT)   rd_hold <= mem_din;
        end
    end

    assign rd_src = slow ? rd_hold : mem_din;
`else
    assign rd_src = mem_din;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            mem_dout <= 8'h00;
            op_we    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mem_addr <= make_phys(page, req_addr[PAGE_BITS-1:0]);
                mem_dout <= req_wdata;
                op_we    <= req_we;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        io_access = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 8'h00;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (is_io) begin
                    io_access = 1'b1;
                end else begin
                    mem_re = !op_we;
                    mem_we = op_we;
                end
`ifdef MPR_BUS_WAIT_EN
                state_nxt = slow ? ST_WAIT : ST_DATA;
`else
                state_nxt = ST_DATA;
`endif
            end
            ST_WAIT: state_nxt = ST_DATA;
            ST_DATA: begin
                rsp_valid = 1'b1;
                if (!op_we) rsp_rdata = is_io ? IO_READ_VALUE : rd_src;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mpr_bus_master.sv
// Scoreboard bench for mpr_bus_master: directed cases plus random traffic
// checked against a page-table/memory reference model.
module tb_mpr_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        mpr_we = 1'b0;
    logic [2:0]  mpr_sel = '0;
    logic [7:0]  mpr_wdata = '0, mpr_rdata;
    logic [20:0] mem_addr;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_re, mem_we, io_access;
    logic        slow_mode = 1'b0;

    mpr_bus_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MPR_BUS_WAIT_EN
        .slow_mode (slow_mode),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mpr_we    (mpr_we),
        .mpr_sel   (mpr_sel),
        .mpr_wdata (mpr_wdata),
        .mpr_rdata (mpr_rdata),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .io_access (io_access)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = -10;

    always @(posedge clk) cyc <= cyc + 1;

    // Background contents of never-written memory, shared by memory and model.
    function automatic logic [7:0] init_byte(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h68;
    endfunction

    // Synchronous memory: registered read data, write on the strobe edge.
    bit [7:0] env_mem [0:2097151];
    bit       env_wr  [0:2097151];
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr] <= mem_dout;
            env_wr[mem_addr]  <= 1'b1;
        end
        if (mem_re) mem_din <= env_wr[mem_addr] ? env_mem[mem_addr] : init_byte(mem_addr);
    end

    // Reference model: page registers and byte-addressed memory contents.
    logic [7:0] m_mpr [8];
    logic [7:0] model_mem [int];

    typedef struct {
        int          cyc;
        logic [20:0] addr;
        logic        we;
        logic        io;
        logic [7:0]  wd;
    } acc_t;
    typedef struct {
        int         cyc;
        logic [7:0] d;
    } rsp_t;

    acc_t acc_q [$];
    rsp_t rsp_q [$];
    int   acc_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        logic [20:0] phys;
        logic        io;
        logic [7:0]  rd;
        int          c0;
        phys = {m_mpr[addr[15:13]], addr[12:0]};
        io   = (phys >= 21'h1F0000);
        c0   = cyc + 1;
        if (we)                               rd = 8'h00;
        else if (io)                          rd = 8'hFF;
        else if (model_mem.exists(int'(phys))) rd = model_mem[int'(phys)];
        else                                  rd = init_byte(phys);
        if (we && !io) model_mem[int'(phys)] = wd;
        acc_q.push_back('{c0, phys, we, io, wd});
        rsp_q.push_back('{c0 + 1, rd});
        last_acc = c0;
        acc_log.push_back(c0);
    endtask

    // Present a request (holding req_valid) until accepted; an optional MPR
    // write is driven in the acceptance cycle only.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic mw, input logic [2:0] ms, input logic [7:0] mwd);
        bit done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = addr;
            req_wdata = wd;
            mpr_we    = 1'b0;
            check("req_ready", req_ready, (cyc >= last_acc + 2));
            if (req_ready) begin
                mpr_we    = mw;
                mpr_sel   = ms;
                mpr_wdata = mwd;
                model_accept(we, addr, wd);
                if (mw) m_mpr[ms] = mwd;
                done = 1;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mpr_we    = 1'b0;
        end
    endtask

    task automatic mpr_write(input logic [2:0] sel, input logic [7:0] val);
        @(negedge clk);
        req_valid = 1'b0;
        mpr_we    = 1'b1;
        mpr_sel   = sel;
        mpr_wdata = val;
        check("mpr_rdata_old", mpr_rdata, m_mpr[sel]);
        m_mpr[sel] = val;
        @(negedge clk);
        mpr_we = 1'b0;
        check("mpr_rdata_new", mpr_rdata, m_mpr[sel]);
    endtask

    // Monitor: strobes and responses must appear exactly in their scheduled cycle.
    always @(negedge clk) begin
        if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
            acc_t e;
            e = acc_q.pop_front();
            check("mem_addr",  mem_addr,  e.addr);
            check("mem_re",    mem_re,    !e.we && !e.io);
            check("mem_we",    mem_we,    e.we && !e.io);
            check("io_access", io_access, e.io);
            if (e.we) check("mem_dout", mem_dout, e.wd);
        end else if (mem_re || mem_we || io_access) begin
            check("unexpected_strobe", {mem_re, mem_we, io_access}, 0);
        end
        if (mem_re || mem_we) check("re_we_exclusive", mem_re && mem_we, 0);
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            rsp_t r;
            r = rsp_q.pop_front();
            check("rsp_valid", rsp_valid, 1);
            check("rsp_rdata", rsp_rdata, r.d);
        end else if (rsp_valid) begin
            check("unexpected_rsp", rsp_valid, 0);
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 8; i++) m_mpr[i] = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_strobes",   {mem_re, mem_we, io_access}, 0);
        check("rst_mem_addr",  mem_addr, 0);
        check("rst_mem_dout",  mem_dout, 0);
        check("rst_mpr_rdata", mpr_rdata, 8'h00);
        rst_n = 1'b1;

        mpr_write(3'd2, 8'h80);
        issue(1'b0, 16'h4123, 8'h00, 1'b0, 3'd0, 8'h00);

        mpr_write(3'd0, 8'h01);
        issue(1'b1, 16'h0010, 8'hC3, 1'b0, 3'd0, 8'h00);
        issue(1'b0, 16'h0010, 8'h00, 1'b0, 3'd0, 8'h00);

        mpr_write(3'd7, 8'hFF);
        issue(1'b0, 16'hE000, 8'h00, 1'b0, 3'd0, 8'h00);
        issue(1'b1, 16'hE000, 8'h77, 1'b0, 3'd0, 8'h00);
        issue(1'b0, 16'hE000, 8'h00, 1'b0, 3'd0, 8'h00);

        issue(1'b0, 16'h2000, 8'h00, 1'b1, 3'd1, 8'h22);
        issue(1'b0, 16'h2000, 8'h00, 1'b0, 3'd0, 8'h00);

        mpr_write(3'd3, 8'hF7);
        issue(1'b0, 16'h7FFF, 8'h00, 1'b0, 3'd0, 8'h00);
        mpr_write(3'd4, 8'hF8);
        issue(1'b0, 16'h8000, 8'h00, 1'b0, 3'd0, 8'h00);
        issue(1'b0, 16'hFFFF, 8'h00, 1'b0, 3'd0, 8'h00);
        idle(2);

        n = acc_log.size();
        issue(1'b0, 16'h4000, 8'h00, 1'b0, 3'd0, 8'h00);
        issue(1'b1, 16'h4001, 8'h11, 1'b0, 3'd0, 8'h00);
        issue(1'b0, 16'h4001, 8'h00, 1'b0, 3'd0, 8'h00);
        check("hold_spacing_1", acc_log[n + 1] - acc_log[n], 3);
        check("hold_spacing_2", acc_log[n + 2] - acc_log[n + 1], 3);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] mv;
            mv = ($urandom_range(0, 2) == 0) ? (8'hF0 | 8'($urandom_range(0, 15)))
                                             : 8'($urandom);
            issue(1'($urandom), 16'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0), 3'($urandom), mv);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        // Reset during ACCESS of a memory read.
        mpr_write(3'd5, 8'h12);
        issue(1'b0, 16'hA000, 8'h00, 1'b0, 3'd0, 8'h00);
        @(posedge clk);
        #1;
        check("pre_rst_mem_re", mem_re, 1);
        rst_n = 1'b0;
        acc_q.delete();
        rsp_q.delete();
        last_acc = -10;
        for (int i = 0; i < 8; i++) m_mpr[i] = 8'h00;
        #1;
        check("rst_mid_mem_re",    mem_re, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("post_rst_ready", req_ready, 1);
        for (int s = 0; s < 8; s++) begin
            mpr_sel = 3'(s);
            #1;
            check("post_rst_mpr", mpr_rdata, m_mpr[s]);
        end

        for (int i = 0; i < 20; i++) begin
            issue(1'($urandom), 16'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0), 3'($urandom), 8'($urandom));
        end

        for (int i = 0; i < 20 && (acc_q.size() > 0 || rsp_q.size() > 0); i++) idle(1);
        check("drain_acc", acc_q.size(), 0);
        check("drain_rsp", rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
